// File: rtl/sprite_motion_ctrl.sv
// Sprite position engine: prescaled motion ticks, step moves with wrap or clamp
// edges, a rise/fall jump arc and a synchronous position load.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  prescaler enable
//   movement[3:0]       [3]=jump, [2:0]: 001 up, 010 left, 011 right, 100 down
//   load, load_x/load_y synchronous position load (clamped to X_MAX/Y_MAX)
//   posx, posy          registered sprite position
//   tick                prescaler terminal count while enabled (combinational)
//   jumping             registered, high while a jump arc is in progress
module sprite_motion_ctrl #(
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9,
  parameter int unsigned X_MAX      = 640,
  parameter int unsigned Y_MAX      = 480,
  parameter int unsigned X_INIT     = 0,
  parameter int unsigned Y_INIT     = 0,
  parameter int unsigned STEP       = 1,
  parameter int unsigned TICK_DIV   = 262144,
  parameter int unsigned WRAP       = 1,
  parameter int unsigned JUMP_TICKS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    movement,
  input  logic          load,
  input  logic [XW-1:0] load_x,
  input  logic [YW-1:0] load_y,
  output logic [XW-1:0] posx,
  output logic [YW-1:0] posy,
  output logic          tick,
  output logic          jumping
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = $clog2(JUMP_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;

  localparam logic [XW:0] XMAX_E = (XW+1)'(X_MAX);
  localparam logic [XW:0] XSTP_E = (XW+1)'(STEP);
  localparam logic [YW:0] YMAX_E = (YW+1)'(Y_MAX);
  localparam logic [YW:0] YSTP_E = (YW+1)'(STEP);

  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [1:0]    state_q, state_nxt;
  logic [RW-1:0] rise_cnt_q, rise_cnt_nxt;
  logic [YW-1:0] base_y_q, base_y_nxt;
  logic [XW-1:0] posx_nxt;
  logic [YW-1:0] posy_nxt;

  logic [XW:0] x_ext, x_left, x_right, x_sum, x_load;
  logic [YW:0] y_ext, y_up, y_down, y_sum, y_sat0, y_fall, y_load;

  assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

  // Extended-width candidate positions; one extra bit keeps sums from overflowing.
  always_comb begin
    x_ext  = {1'b0, posx};
    y_ext  = {1'b0, posy};
    x_sum  = x_ext + XSTP_E;
    y_sum  = y_ext + YSTP_E;
    x_left = '0;
    y_up   = '0;
    if (x_ext >= XSTP_E)  x_left = x_ext - XSTP_E;
    else if (WRAP != 0)   x_left = x_ext + (XMAX_E + (XW+1)'(1) - XSTP_E);
    if (y_ext >= YSTP_E)  y_up = y_ext - YSTP_E;
    else if (WRAP != 0)   y_up = y_ext + (YMAX_E + (YW+1)'(1) - YSTP_E);
    x_right = x_sum;
    y_down  = y_sum;
    if (x_sum > XMAX_E) x_right = (WRAP != 0) ? (x_sum - XMAX_E - (XW+1)'(1)) : XMAX_E;
    if (y_sum > YMAX_E) y_down  = (WRAP != 0) ? (y_sum - YMAX_E - (YW+1)'(1)) : YMAX_E;
    // Jump rise never wraps; fall is capped at the take-off height.
    y_sat0 = (y_ext >= YSTP_E) ? (y_ext - YSTP_E) : '0;
    y_fall = (y_sum > {1'b0, base_y_q}) ? {1'b0, base_y_q} : y_sum;
    x_load = ({1'b0, load_x} > XMAX_E) ? XMAX_E : {1'b0, load_x};
    y_load = ({1'b0, load_y} > YMAX_E) ? YMAX_E : {1'b0, load_y};
  end

  // Next-state: load beats tick; otherwise everything moves only on a tick.
  always_comb begin
    cnt_nxt      = cnt_q;
    state_nxt    = state_q;
    rise_cnt_nxt = rise_cnt_q;
    base_y_nxt   = base_y_q;
    posx_nxt     = posx;
    posy_nxt     = posy;

    if (en) cnt_nxt = tick ? '0 : (cnt_q + CW'(1));

    if (load) begin
      posx_nxt     = XW'(x_load);
      posy_nxt     = YW'(y_load);
      state_nxt    = S_IDLE;
      rise_cnt_nxt = '0;
    end else if (tick) begin
      case (movement[2:0])
        3'b010:  posx_nxt = XW'(x_left);
        3'b011:  posx_nxt = XW'(x_right);
        default: posx_nxt = posx;
      endcase

      case (state_q)
        S_IDLE: begin
          if (movement[3]) begin
            state_nxt    = S_RISE;
            base_y_nxt   = posy;
            posy_nxt     = YW'(y_sat0);
            rise_cnt_nxt = RW'(1);
          end else if (movement[2:0] == 3'b001) begin
            posy_nxt = YW'(y_up);
          end else if (movement[2:0] == 3'b100) begin
            posy_nxt = YW'(y_down);
          end
        end
        S_RISE: begin
          if (rise_cnt_q < RW'(JUMP_TICKS)) begin
            posy_nxt     = YW'(y_sat0);
            rise_cnt_nxt = rise_cnt_q + RW'(1);
          end else begin
            state_nxt = S_FALL;
            posy_nxt  = YW'(y_fall);
          end
        end
        S_FALL: begin
          posy_nxt = YW'(y_fall);
          if (y_fall == {1'b0, base_y_q}) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      rise_cnt_q <= '0;
      base_y_q   <= '0;
      posx       <= XW'(X_INIT);
      posy       <= YW'(Y_INIT);
      jumping    <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      state_q    <= state_nxt;
      rise_cnt_q <= rise_cnt_nxt;
      base_y_q   <= base_y_nxt;
      posx       <= posx_nxt;
      posy       <= posy_nxt;
      jumping    <= (state_nxt != S_IDLE);
    end
  end

endmodule
